axi4_master_read_engine: RTL and testbench

//  AXI4 read master: accepts one read command at a time from a local client and issues it on AR.

---
 rtl/axi4_pkg.sv | 29 ++
 rtl/axi4_skid_fifo.sv | 61 ++++++
 rtl/axi4_master_read_engine.sv | 154 +++++++++++++++
 tb/tb_axi4_master_read_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 types for the test system: burst encodings, response codes,
// the read-master state set and the response-merge helper.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA,
    RD_DRAIN,
    RD_DONE
  } rd_mst_state_t;

  // The encodings are already ordered by severity, so the worst is the larger.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_skid_fifo.sv
// Small registered-output FIFO that absorbs beats while rready turns around.
// Flush empties it in one cycle; contents are not cleared on flush.
module axi4_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/axi4_master_read_engine.sv
// AXI4 read master: one outstanding burst, R beats buffered to the client,
// ID/RLAST/beat-count checking, worst-case RRESP merge and stall timeout.
module axi4_master_read_engine
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic                  usr_valid,
  input  logic                  usr_ready,
  output logic [DATA_WIDTH-1:0] usr_data,
  output logic                  usr_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  err_id,
  output logic                  err_last,
  output logic                  err_timeout
);

  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  rd_mst_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  burst_t                arburst_q;
  logic [7:0]            beat_cnt;
  logic [SW-1:0]         stall_cnt;
  logic [1:0]            resp_q;

  logic cmd_fire, ar_fire, r_fire, last_beat, stall, timeout;
  logic fifo_in_ready, fifo_full, fifo_empty;
  logic [DATA_WIDTH:0] fifo_out;

  assign cmd_ready = (state_q == RD_IDLE);
  assign arvalid   = (state_q == RD_ADDR);
  assign rready    = (state_q == RD_DATA) && fifo_in_ready;
  assign cmd_fire  = cmd_ready && cmd_valid;
  assign ar_fire   = arvalid && arready;
  assign r_fire    = rvalid && rready;
  assign last_beat = (beat_cnt == arlen_q);
  // A full FIFO is back-pressure from the client, not a slave stall.
  assign stall     = (arvalid && !arready) ||
                     ((state_q == RD_DATA) && !rvalid && !fifo_full);
  assign timeout   = stall && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

  assign araddr    = araddr_q;
  assign arid      = arid_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = arburst_q;
  assign usr_data  = fifo_out[DATA_WIDTH-1:0];
  assign usr_last  = fifo_out[DATA_WIDTH];
  assign done      = (state_q == RD_DONE);
  assign done_resp = done ? resp_q : 2'b00;

  axi4_skid_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (timeout),
    .in_valid  (r_fire),
    .in_ready  (fifo_in_ready),
    .in_data   ({last_beat, rdata}),
    .out_valid (usr_valid),
    .out_ready (usr_ready),
    .out_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:  if (cmd_fire) state_d = RD_ADDR;
      RD_ADDR:  if (timeout) state_d = RD_DONE;
                else if (ar_fire) state_d = RD_DATA;
      RD_DATA:  if (timeout) state_d = RD_DONE;
                else if (r_fire && last_beat) state_d = RD_DRAIN;
      RD_DRAIN: if (fifo_empty) state_d = RD_DONE;
      RD_DONE:  state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RD_IDLE;
      araddr_q    <= '0;
      arid_q      <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= BURST_FIXED;
      beat_cnt    <= '0;
      stall_cnt   <= '0;
      resp_q      <= RESP_OKAY;
      err_id      <= 1'b0;
      err_last    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ar_fire || r_fire) stall_cnt <= '0;
      else if (stall)        stall_cnt <= stall_cnt + SW'(1);
      if (cmd_fire) begin
        araddr_q    <= cmd_addr;
        arid_q      <= cmd_id;
        arlen_q     <= cmd_len;
        arsize_q    <= cmd_size;
        arburst_q   <= burst_t'(cmd_burst);
        beat_cnt    <= '0;
        stall_cnt   <= '0;
        resp_q      <= RESP_OKAY;
        err_id      <= 1'b0;
        err_last    <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (r_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
        resp_q   <= resp_worst(resp_q, rresp);
        if (rid != arid_q)      err_id   <= 1'b1;
        if (rlast != last_beat) err_last <= 1'b1;
      end
      if (timeout) begin
        err_timeout <= 1'b1;
        resp_q      <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4_master_read_engine.sv
// Directed and randomized bursts against the read master, checked against
// a transaction-level model of beat order, FIFO occupancy and status rules.
module tb_axi4_master_read_engine;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_id = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [3:0]  rid = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        usr_valid, usr_ready = 1'b0;
  logic [31:0] usr_data;
  logic        usr_last;
  logic        done;
  logic [1:0]  done_resp;
  logic        err_id, err_last, err_timeout;

  int checks = 0;
  int fails  = 0;

  logic [31:0] b_data [256];
  logic [3:0]  b_id   [256];
  logic [1:0]  b_resp [256];
  logic        b_last [256];

  always #5 clk = ~clk;

  axi4_master_read_engine #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_id(cmd_id),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_data(usr_data), .usr_last(usr_last),
    .done(done), .done_resp(done_resp),
    .err_id(err_id), .err_last(err_last), .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_beats(input int len, input logic [3:0] id);
    for (int i = 0; i <= len; i++) begin
      b_data[i] = $urandom;
      b_id[i]   = id;
      b_resp[i] = 2'b00;
      b_last[i] = (i == len);
    end
  endtask

  task automatic issue_cmd(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_id = id;
    cmd_len = 8'(len); cmd_size = size; cmd_burst = burst;
    #1 check("cmd_ready_idle", cmd_ready, 1);
  endtask

  // pattern=1 drives usr_ready as 1-0-0-1 repeating; rst_after>=0 resets once that many beats are accepted.
  task automatic run_burst(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input int ar_delay, input int rv_pct, input int ur_pct,
                           input int hold0, input bit pattern, input int rst_after);
    int acc = 0, pops = 0, cyc = 0, gap = 0, occ;
    bit prev_empty = 0, seen_done = 0, drained;
    logic       x_id = 0, x_last = 0;
    logic [1:0] x_resp = 2'b00;
    logic [2:0] size  = 3'($urandom_range(2));
    logic [1:0] burst = 2'($urandom_range(2));
    for (int i = 0; i <= len; i++) begin
      if (b_id[i] != id) x_id = 1;
      if (b_last[i] != (i == len)) x_last = 1;
      if (b_resp[i] > x_resp) x_resp = b_resp[i];
    end
    issue_cmd(addr, id, len, size, burst);
    for (int d = 0; d <= ar_delay; d++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      arready = (d == ar_delay);
      #1;
      check("arvalid_held", arvalid, 1);
      check("ar_payload", {araddr, arid, arlen, arsize, arburst},
            {addr, id, 8'(len), size, burst});
    end
    while (cyc < 3000) begin
      @(negedge clk);
      arready = 1'b0;
      if (rst_after >= 0 && acc == rst_after) begin
        rst = 1'b1; rvalid = 1'b0; usr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_usr_valid", usr_valid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_done", done, 0);
        return;
      end
      if (acc <= len && (gap >= 8 || $urandom_range(99) < rv_pct)) begin
        rvalid = 1'b1; rdata = b_data[acc]; rid = b_id[acc];
        rresp = b_resp[acc]; rlast = b_last[acc]; gap = 0;
      end else begin
        rvalid = 1'b0; gap++;
      end
      if (pattern) usr_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else usr_ready = (cyc < hold0) ? 1'b0 : ($urandom_range(99) < ur_pct);
      #1;
      occ = acc - pops;
      check("rready", rready, (acc <= len) && (occ < 2));
      check("usr_valid", usr_valid, occ > 0);
      check("done", done, prev_empty);
      if (done) begin
        check("done_resp", done_resp, x_resp);
        check("err_id", err_id, x_id);
        check("err_last", err_last, x_last);
        check("err_timeout", err_timeout, 0);
        check("beats_out", pops, len + 1);
        seen_done = 1;
        break;
      end
      drained = (acc == len + 1) && (occ == 0);
      if (usr_valid && usr_ready) begin
        check("usr_data", usr_data, b_data[pops]);
        check("usr_last", usr_last, pops == len);
        pops++;
      end
      if (rvalid && rready) acc++;
      prev_empty = drained;
      cyc++;
    end
    check("done_seen", seen_done, 1);
    @(negedge clk);
    rvalid = 1'b0; usr_ready = 1'b0;
    #1;
    check("back_to_idle", {cmd_ready, done}, 2'b10);
  endtask

  initial begin
    // reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    check("reset_outputs", {cmd_ready, arvalid, rready, usr_valid, done, done_resp,
                            err_id, err_last, err_timeout}, 10'b1_0000_00000);
    check("reset_araddr", araddr, 0);
    rst = 1'b0;

    // 1: INCR len=3, data A0..A3
    set_beats(3, 4'd5);
    for (int i = 0; i < 4; i++) b_data[i] = 32'hA0 + 32'(i);
    run_burst(32'h100, 4'd5, 3, 0, 100, 100, 0, 0, -1);

    // 2: usr_ready 1-0-0-1, slave always valid
    run_burst(32'h100, 4'd5, 3, 1, 100, 0, 0, 1, -1);

    // 3: merged response 10 then 11
    set_beats(1, 4'd2);
    b_resp[0] = 2'b10; b_resp[1] = 2'b11;
    run_burst(32'h200, 4'd2, 1, 0, 100, 100, 0, 0, -1);

    // 4: early rlast on beat 1, wrong id on beat 0
    set_beats(2, 4'd5);
    b_last[1] = 1'b1; b_id[0] = 4'd3;
    run_burst(32'h300, 4'd5, 2, 0, 100, 100, 0, 0, -1);

    // 5: AR timeout, then a clean command
    issue_cmd(32'h400, 4'd1, 0, 3'd2, 2'b01);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; arready = 1'b0;
      #1;
      check("to_arvalid", arvalid, 1);
      check("to_no_done", done, 0);
    end
    @(negedge clk); #1;
    check("to_arvalid_drop", arvalid, 0);
    check("to_done", done, 1);
    check("to_resp", done_resp, 2'b10);
    check("to_err", err_timeout, 1);
    @(negedge clk); #1;
    check("to_idle", cmd_ready, 1);
    set_beats(0, 4'd1);
    run_burst(32'h404, 4'd1, 0, 0, 100, 100, 0, 0, -1);

    // 6: reset after beat 1 of len=7
    set_beats(7, 4'd6);
    run_burst(32'h500, 4'd6, 7, 0, 100, 0, 100, 0, 2);
    set_beats(2, 4'd6);
    run_burst(32'h600, 4'd6, 2, 0, 100, 100, 0, 0, -1);

    // usr_ready held low well past the timeout: back-pressure only
    set_beats(5, 4'd7);
    run_burst(32'h700, 4'd7, 5, 0, 100, 100, 40, 0, -1);

    // randomized bursts
    for (int t = 0; t < 25; t++) begin
      int len = $urandom_range(15);
      logic [3:0] id = 4'($urandom);
      set_beats(len, id);
      for (int i = 0; i <= len; i++) begin
        b_resp[i] = 2'($urandom);
        if ($urandom_range(9) == 0) b_id[i] = id ^ 4'h1;
        if ($urandom_range(19) == 0) b_last[i] = ~b_last[i];
      end
      run_burst($urandom, id, len, $urandom_range(5), $urandom_range(100, 30),
                $urandom_range(100, 20), ($urandom_range(3) == 0) ? 30 : 0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
